// File: rtl/boot_sequencer_pkg.sv
// Shared types and defaults for the boot sequencer: state encoding, output bundle
// and the per-state output decode used to load the registered outputs.
package boot_sequencer_pkg;

  localparam int unsigned CNT_W           = 32;
  localparam int unsigned LOAD_CYCLES_DEF = 1;
  localparam int unsigned RUN_CYCLES_DEF  = 34;

  typedef enum logic [2:0] {
    IDLE,
    MEM_RST,
    MEM_LOAD,
    UNIT_RST,
    UC_RST,
    RUN,
    DUMP,
    DONE
  } state_t;

  typedef struct packed {
    logic im_rst;
    logic dm_rst;
    logic im_rd;
    logic dm_rd;
    logic im_wr;
    logic dm_wr;
    logic pc_rst;
    logic rb_rst;
    logic tf_rst;
    logic rf_rst;
    logic uc_rst;
    logic running;
    logic done;
  } outs_t;

  // Moore decode: outputs depend only on the state being entered.
  function automatic outs_t state_outputs(state_t s);
    outs_t o;
    o = '0;
    case (s)
      IDLE, MEM_RST: begin
        o.im_rst = 1'b1;
        o.dm_rst = 1'b1;
        o.pc_rst = 1'b1;
        o.rb_rst = 1'b1;
        o.tf_rst = 1'b1;
        o.rf_rst = 1'b1;
        o.uc_rst = 1'b1;
      end
      MEM_LOAD: begin
        o.im_rd  = 1'b1;
        o.dm_rd  = 1'b1;
        o.pc_rst = 1'b1;
        o.rb_rst = 1'b1;
        o.tf_rst = 1'b1;
        o.rf_rst = 1'b1;
        o.uc_rst = 1'b1;
      end
      UNIT_RST: begin
        o.pc_rst = 1'b1;
        o.rb_rst = 1'b1;
        o.tf_rst = 1'b1;
        o.rf_rst = 1'b1;
        o.uc_rst = 1'b1;
      end
      UC_RST:  o.uc_rst  = 1'b1;
      RUN:     o.running = 1'b1;
      DUMP: begin
        o.im_wr = 1'b1;
        o.dm_wr = 1'b1;
      end
      DONE:    o.done = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/boot_sequencer_seq_counter.sv
// Loadable down-counter with a zero flag; times the memory load window and the run limit.
module seq_counter #(
  parameter int unsigned W = 32
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && count != '0)
      count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/boot_sequencer.sv
// Processor boot sequencer: memory reset/load, datapath and control-unit reset release,
// bounded or halt-terminated run, memory dump. All outputs come straight from flops.
//
// state    | meaning
// IDLE     | everything held in reset, waiting for start
// MEM_RST  | one cycle of full reset before loading memories
// MEM_LOAD | memories out of reset, image load strobes high for LOAD_CYCLES
// UNIT_RST | load finished, datapath and control unit still in reset
// UC_RST   | datapath released, control unit held one more cycle
// RUN      | processor running, run_count counting
// DUMP     | one cycle of memory image dump strobes
// DONE     | finished, run_count held, start re-boots
module boot_sequencer
  import boot_sequencer_pkg::*;
#(
  parameter int unsigned LOAD_CYCLES = LOAD_CYCLES_DEF,
  parameter int unsigned RUN_CYCLES  = RUN_CYCLES_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic             halt,
  output logic             im_RESET,
  output logic             dm_RESET,
  output logic             im_read_file,
  output logic             dm_read_file,
  output logic             im_write_file,
  output logic             dm_write_file,
  output logic             pc_RESET,
  output logic             rb_RESET,
  output logic             tf_RESET,
  output logic             rf_RESET,
  output logic             uc_RESET,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] run_count
);

  state_t             state, next_state;
  outs_t              outs_q;
  logic               cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]   cnt_load_val;

  seq_counter #(.W(CNT_W)) u_seq_counter (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      outs_q <= state_outputs(IDLE);
    end else begin
      state  <= next_state;
      outs_q <= state_outputs(next_state);
    end
  end

  // The counter is loaded with length-1 on entry so its zero flag marks the last cycle.
  always_comb begin
    next_state   = state;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state)
      IDLE:     if (start) next_state = MEM_RST;
      MEM_RST: begin
        next_state   = MEM_LOAD;
        cnt_load     = 1'b1;
        cnt_load_val = CNT_W'(LOAD_CYCLES - 1);
      end
      MEM_LOAD: begin
        if (cnt_zero) next_state = UNIT_RST;
        else          cnt_dec    = 1'b1;
      end
      UNIT_RST: next_state = UC_RST;
      UC_RST: begin
        next_state   = RUN;
        cnt_load     = 1'b1;
        cnt_load_val = CNT_W'(RUN_CYCLES - 1);
      end
      RUN: begin
        cnt_dec = 1'b1;
        if (halt || (RUN_CYCLES != 0 && cnt_zero)) next_state = DUMP;
      end
      DUMP:     next_state = DONE;
      DONE:     if (start) next_state = MEM_RST;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      run_count <= '0;
    else if ((state == IDLE || state == DONE) && start)
      run_count <= '0;
    else if (state == RUN && run_count != '1)
      run_count <= run_count + CNT_W'(1);
  end

  assign im_RESET      = outs_q.im_rst;
  assign dm_RESET      = outs_q.dm_rst;
  assign im_read_file  = outs_q.im_rd;
  assign dm_read_file  = outs_q.dm_rd;
  assign im_write_file = outs_q.im_wr;
  assign dm_write_file = outs_q.dm_wr;
  assign pc_RESET      = outs_q.pc_rst;
  assign rb_RESET      = outs_q.rb_rst;
  assign tf_RESET      = outs_q.tf_rst;
  assign rf_RESET      = outs_q.rf_rst;
  assign uc_RESET      = outs_q.uc_rst;
  assign running       = outs_q.running;
  assign done          = outs_q.done;

endmodule

// File: tb/tb_boot_sequencer.sv
// Bench for boot_sequencer: two instances (LOAD=1/RUN=34 and LOAD=4/unbounded run)
// checked every cycle against a phase/position reference model.
module tb_boot_sequencer;

  localparam int L_A = 1;
  localparam int R_A = 34;
  localparam int L_B = 4;
  localparam int R_B = 0;

  // {im_rst, dm_rst, im_rd, dm_rd, im_wr, dm_wr, pc, rb, tf, rf, uc, running, done}
  localparam logic [12:0] V_IDLE = 13'b1_1_0_0_0_0_1_1_1_1_1_0_0;
  localparam logic [12:0] V_LOAD = 13'b0_0_1_1_0_0_1_1_1_1_1_0_0;
  localparam logic [12:0] V_UNIT = 13'b0_0_0_0_0_0_1_1_1_1_1_0_0;
  localparam logic [12:0] V_UC   = 13'b0_0_0_0_0_0_0_0_0_0_1_0_0;
  localparam logic [12:0] V_RUN  = 13'b0_0_0_0_0_0_0_0_0_0_0_1_0;
  localparam logic [12:0] V_DUMP = 13'b0_0_0_0_1_1_0_0_0_0_0_0_0;
  localparam logic [12:0] V_DONE = 13'b0_0_0_0_0_0_0_0_0_0_0_0_1;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic start_a = 1'b0, halt_a = 1'b0, start_b = 1'b0, halt_b = 1'b0;

  logic im_rst_a, dm_rst_a, im_rd_a, dm_rd_a, im_wr_a, dm_wr_a;
  logic pc_rst_a, rb_rst_a, tf_rst_a, rf_rst_a, uc_rst_a, running_a, done_a;
  logic [31:0] rc_a;
  logic im_rst_b, dm_rst_b, im_rd_b, dm_rd_b, im_wr_b, dm_wr_b;
  logic pc_rst_b, rb_rst_b, tf_rst_b, rf_rst_b, uc_rst_b, running_b, done_b;
  logic [31:0] rc_b;

  always #5 CLK = ~CLK;

  boot_sequencer #(.LOAD_CYCLES(L_A), .RUN_CYCLES(R_A)) dut_a (
    .CLK(CLK), .RESET(RESET), .start(start_a), .halt(halt_a),
    .im_RESET(im_rst_a), .dm_RESET(dm_rst_a),
    .im_read_file(im_rd_a), .dm_read_file(dm_rd_a),
    .im_write_file(im_wr_a), .dm_write_file(dm_wr_a),
    .pc_RESET(pc_rst_a), .rb_RESET(rb_rst_a), .tf_RESET(tf_rst_a), .rf_RESET(rf_rst_a),
    .uc_RESET(uc_rst_a), .running(running_a), .done(done_a), .run_count(rc_a)
  );

  boot_sequencer #(.LOAD_CYCLES(L_B), .RUN_CYCLES(R_B)) dut_b (
    .CLK(CLK), .RESET(RESET), .start(start_b), .halt(halt_b),
    .im_RESET(im_rst_b), .dm_RESET(dm_rst_b),
    .im_read_file(im_rd_b), .dm_read_file(dm_rd_b),
    .im_write_file(im_wr_b), .dm_write_file(dm_wr_b),
    .pc_RESET(pc_rst_b), .rb_RESET(rb_rst_b), .tf_RESET(tf_rst_b), .rf_RESET(rf_rst_b),
    .uc_RESET(uc_rst_b), .running(running_b), .done(done_b), .run_count(rc_b)
  );

  wire [12:0] act_a = {im_rst_a, dm_rst_a, im_rd_a, dm_rd_a, im_wr_a, dm_wr_a,
                       pc_rst_a, rb_rst_a, tf_rst_a, rf_rst_a, uc_rst_a, running_a, done_a};
  wire [12:0] act_b = {im_rst_b, dm_rst_b, im_rd_b, dm_rd_b, im_wr_b, dm_wr_b,
                       pc_rst_b, rb_rst_b, tf_rst_b, rf_rst_b, uc_rst_b, running_b, done_b};

  int errors = 0;
  int checks = 0;

  // Model: phase 0 idle, 1 sequencing (pos = cycle index), 2 run, 3 dump, 4 done.
  int          phase   [2];
  int          pos     [2];
  logic [31:0] exp_cnt [2];
  logic [12:0] exp_v   [2];
  logic        prev_uc [2];
  logic        prev_pc [2];

  function automatic logic [12:0] phase_vec(int ph, int p, int l);
    if (ph == 0)      return V_IDLE;
    else if (ph == 1) begin
      if (p == 0)          return V_IDLE;
      else if (p <= l)     return V_LOAD;
      else if (p == l + 1) return V_UNIT;
      else                 return V_UC;
    end
    else if (ph == 2) return V_RUN;
    else if (ph == 3) return V_DUMP;
    else              return V_DONE;
  endfunction

  task automatic model_edge(input int i, input logic s, input logic h, input logic r);
    int l;
    int rl;
    l  = (i == 0) ? L_A : L_B;
    rl = (i == 0) ? R_A : R_B;
    if (r) begin
      phase[i] = 0; pos[i] = 0; exp_cnt[i] = 0;
    end else begin
      case (phase[i])
        0, 4: if (s) begin phase[i] = 1; pos[i] = 0; exp_cnt[i] = 0; end
        1: begin
          pos[i] = pos[i] + 1;
          if (pos[i] > l + 2) phase[i] = 2;
        end
        2: begin
          if (exp_cnt[i] != 32'hFFFF_FFFF) exp_cnt[i] = exp_cnt[i] + 1;
          if (h || (rl != 0 && exp_cnt[i] == 32'(rl))) phase[i] = 3;
        end
        3: phase[i] = 4;
        default: phase[i] = 0;
      endcase
    end
    exp_v[i] = phase_vec(phase[i], pos[i], l);
  endtask

  task automatic check_inst(input int i, input logic [12:0] act, input logic [31:0] rc);
    checks++;
    assert (act === exp_v[i]) else begin
      errors++;
      $error("FAIL outputs[%0d] t=%0t: observed %b expected %b", i, $time, act, exp_v[i]);
    end
    checks++;
    assert (rc === exp_cnt[i]) else begin
      errors++;
      $error("FAIL run_count[%0d] t=%0t: observed %0d expected %0d", i, $time, rc, exp_cnt[i]);
    end
    checks++;
    assert (((act[10] | act[9]) & (act[8] | act[7])) === 1'b0) else begin
      errors++;
      $error("FAIL rd_wr_overlap[%0d] t=%0t: observed rd=%b%b wr=%b%b expected no overlap",
             i, $time, act[10], act[9], act[8], act[7]);
    end
    if (prev_uc[i] === 1'b1 && act[2] === 1'b0) begin
      checks++;
      assert (prev_pc[i] === 1'b0) else begin
        errors++;
        $error("FAIL uc_before_pc[%0d] t=%0t: observed pc_prev=%b expected 0", i, $time, prev_pc[i]);
      end
    end
    prev_uc[i] = act[2];
    prev_pc[i] = act[6];
  endtask

  task automatic check_all();
    check_inst(0, act_a, rc_a);
    check_inst(1, act_b, rc_b);
  endtask

  task automatic tick();
    logic sa, sb, ha, hb, r;
    sa = start_a; sb = start_b; ha = halt_a; hb = halt_b; r = RESET;
    @(posedge CLK);
    model_edge(0, sa, ha, r);
    model_edge(1, sb, hb, r);
    #1 check_all();
  endtask

  task automatic reset_now();
    RESET = 1'b1;
    #1;
    model_edge(0, 1'b0, 1'b0, 1'b1);
    model_edge(1, 1'b0, 1'b0, 1'b1);
    check_all();
  endtask

  task automatic bound_check(input string tag, input int guard, input int limit);
    checks++;
    assert (guard < limit) else begin
      errors++;
      $error("FAIL %s: observed %0d cycles expected < %0d", tag, guard, limit);
    end
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 2; i++) begin
      phase[i] = 0; pos[i] = 0; exp_cnt[i] = 0; exp_v[i] = V_IDLE;
      prev_uc[i] = 1'b1; prev_pc[i] = 1'b1;
    end

    // Reset with start already high: must not leave IDLE until RESET drops.
    #2 start_b = 1'b1;
    reset_now();
    tick(); tick();
    RESET = 1'b0;
    tick();
    start_b = 1'b0;

    // halt in IDLE does nothing
    halt_a = 1'b1;
    repeat (3) tick();
    halt_a = 1'b0;

    // Full boot on A (start ignored mid-run); B halted at RUN cycle 10.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    guard = 0;
    while ((phase[0] != 4 || phase[1] != 4) && guard < 300) begin
      start_a = (phase[0] == 2 && exp_cnt[0] >= 5 && exp_cnt[0] <= 8);
      halt_b  = (phase[1] == 2 && exp_cnt[1] == 9);
      tick();
      guard++;
    end
    start_a = 1'b0; halt_b = 1'b0;
    bound_check("boot_to_done", guard, 300);

    // halt in DONE does nothing
    halt_a = 1'b1; halt_b = 1'b1;
    repeat (3) tick();
    halt_a = 1'b0; halt_b = 1'b0;

    // start held high: back-to-back boots
    start_a = 1'b1;
    repeat (130) tick();
    start_a = 1'b0;

    // RESET in the middle of B's load window
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    guard = 0;
    while (!(phase[1] == 1 && pos[1] == 2) && guard < 20) begin
      tick();
      guard++;
    end
    bound_check("reach_mem_load", guard, 20);
    #2 reset_now();
    tick(); tick();
    RESET = 1'b0;
    repeat (60) tick();

    // Randomised start/halt with occasional mid-cycle reset pulses
    for (int n = 0; n < 800; n++) begin
      start_a = ($urandom_range(0, 7) == 0);
      start_b = ($urandom_range(0, 7) == 0);
      halt_a  = ($urandom_range(0, 15) == 0);
      halt_b  = ($urandom_range(0, 15) == 0);
      tick();
      if ($urandom_range(0, 199) == 0) begin
        #2 reset_now();
        #1 RESET = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
